addr8s_result_checker: RTL
==========================

Name: addr8s_result_checker

Overview:
- Sequential stage downstream of the 8-bit signed fault-resilient adder cores.
- Accepts operand pairs over a valid/ready handshake and drives them into an external combinational adder instance (addr8s_* family).
- Waits for the adder to settle, samples its 9-bit sum, and compares it against an internally computed golden sum.
- Returns the adder's result with a per-operation error flag, and keeps saturating operation and mismatch counters for fault-campaign statistics.

Parameters:
SETTLE_CYCLES, 2, cycles adr_a/adr_b are held before adr_sum is sampled; legal range 1..15
CNT_W, 16, width of op_cnt and err_cnt

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  checker can accept an operand pair
in_a  input  8  operand A, two's complement
in_b  input  8  operand B, two's complement
adr_a  output  8  to adder A[7:0]
adr_b  output  8  to adder B[7:0]
adr_sum  input  9  from adder O[8:0]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  9  sampled adder result
out_err  output  1  out_sum differs from golden sum
err_sticky  output  1  set on any mismatch since reset or clear
op_cnt  output  CNT_W  completed checks, saturating
err_cnt  output  CNT_W  mismatching checks, saturating
clr_cnt  input  1  synchronous clear of op_cnt, err_cnt and err_sticky

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). All state is reset by rst_n.
- Reset values:
  - State is IDLE.
  - in_ready=0, out_valid=0, out_err=0, err_sticky=0.
  - adr_a, adr_b, out_sum, op_cnt and err_cnt are all 0.
- in_ready is a register. It sets on the first clk edge after rst_n deasserts.
- FSM states: IDLE, SETTLE, OUT.
- IDLE (in_ready=1):
  - On an edge with in_valid=1, latch in_a into adr_a and in_b into adr_b.
  - Load the settle counter with SETTLE_CYCLES, clear in_ready, and go to SETTLE.
- SETTLE:
  - adr_a and adr_b are held stable.
  - The settle counter decrements each edge.
  - On the edge where the counter reaches 0:
    - sample adr_sum into out_sum;
    - set out_err = (adr_sum != golden);
    - increment op_cnt, and increment err_cnt if there is a mismatch;
    - set err_sticky if there is a mismatch;
    - set out_valid and go to OUT.
- Golden sum:
  - golden = {in_a[7],in_a} + {in_b[7],in_b}, computed modulo 2^9 from the latched operands.
  - Examples: 127+1 = 9'h080; -128+(-128) = 9'h100; -1+1 = 9'h000.
- OUT:
  - out_valid=1; out_sum and out_err are held stable until handshake.
  - On an edge with out_ready=1: clear out_valid, set in_ready, go to IDLE.
  - out_sum and out_err keep their last values after handshake.
- Latency:
  - Accept edge T0. out_valid is visible after edge T0+SETTLE_CYCLES.
  - Earliest output handshake is edge T0+SETTLE_CYCLES+1.
  - Earliest next accept is edge T0+SETTLE_CYCLES+2.
  - One operation is in flight at a time; in_valid is ignored outside IDLE.
- Counters:
  - Saturate at all-ones and never wrap.
  - err_cnt <= op_cnt always.
- clr_cnt:
  - Clears op_cnt, err_cnt and err_sticky on the next edge.
  - If it coincides with the sampling edge, the clear wins and that operation is not counted or made sticky; out_err still reflects that operation.
  - It does not affect the FSM, out_valid, out_sum or out_err.
- rst_n asserted mid-operation: immediate return to the reset values. The in-flight operation is discarded and not counted.
- adr_sum is only sampled in SETTLE; its value in any other state is don't-care.

Test Plan:
- Reset release, then in_a=8'h7F, in_b=8'h01 with an ideal adder model, SETTLE_CYCLES=2 -> out_valid after accept edge+2, out_sum=9'h080, out_err=0, op_cnt=1, err_cnt=0.
- in_a=8'h80, in_b=8'h80, then in_a=8'hFF, in_b=8'h01 back-to-back with out_ready tied 1 -> out_sum 9'h100 then 9'h000; second accept 4 edges after the first; in_ready low between them.
- Adder model forced to return golden XOR 9'h004 for in_a=8'h10, in_b=8'h20 -> out_sum=9'h034, out_err=1, err_sticky=1, err_cnt=1; next correct operation gives out_err=0 with err_sticky still 1.
- out_ready held 0 for 5 cycles in OUT while in_valid=1 and in_a/in_b change -> out_sum and out_err stable, in_ready=0, no new accept, op_cnt unchanged until handshake.
- CNT_W=2, five forced-mismatch operations -> op_cnt and err_cnt stop at 3; clr_cnt pulsed on a sampling edge -> both counters 0 and err_sticky 0 next cycle, but out_err=1 for that operation.
- rst_n pulsed low during SETTLE -> outputs return to reset values immediately; in_ready=1 one edge after release; counters 0.

Source files
------------

// File: rtl/addr8s_result_checker_if.sv
// Operand/result handshake bundle for addr8s_result_checker.
// The master side supplies operands and accepts results; the slave side is the checker.
interface addr8s_result_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_sum;
  logic       out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_err
  );
endinterface

// File: rtl/addr8s_result_checker.sv
// Drives one operand pair at a time into an external addr8s_* adder, samples its sum
// after a settle delay, flags mismatches against a golden sum and keeps fault statistics.
module addr8s_result_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  addr8s_result_checker_if.slave bus,
  output logic [7:0]             adr_a,
  output logic [7:0]             adr_b,
  input  logic [8:0]             adr_sum,
  output logic                   err_sticky,
  output logic [CNT_W-1:0]       op_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  input  logic                   clr_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        settle_cnt;
  logic              accept;
  logic              sample;
  logic              release_op;
  logic signed [7:0] a_s;
  logic signed [7:0] b_s;
  logic signed [8:0] golden;
  logic              mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  // Golden sum from the latched operands, 9-bit result so overflow is representable
  assign a_s      = adr_a;
  assign b_s      = adr_b;
  assign golden   = $signed({a_s[7], a_s}) + $signed({b_s[7], b_s});
  assign mismatch = (adr_sum != $unsigned(golden));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)     state_nxt = SETTLE;
      SETTLE:  if (sample)     state_nxt = OUT;
      OUT:     if (release_op) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // The counter is sampled on the edge where it would step from 1 to 0
  always_comb begin
    accept     = 1'b0;
    sample     = 1'b0;
    release_op = 1'b0;
    unique case (state)
      IDLE:    accept     = bus.in_ready && bus.in_valid;
      SETTLE:  sample     = (settle_cnt == 4'd1);
      OUT:     release_op = bus.out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_err   <= 1'b0;
      adr_a         <= '0;
      adr_b         <= '0;
      settle_cnt    <= '0;
    end else begin
      bus.in_ready  <= (state_nxt == IDLE);
      bus.out_valid <= (state_nxt == OUT);
      if (accept) begin
        adr_a      <= bus.in_a;
        adr_b      <= bus.in_b;
        settle_cnt <= 4'(SETTLE_CYCLES);
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (sample) begin
        bus.out_sum <= adr_sum;
        bus.out_err <= mismatch;
      end
    end
  end

  // A clear coinciding with a sample wins: that operation is neither counted nor sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt     <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr_cnt) begin
      op_cnt     <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (sample) begin
      op_cnt     <= sat_inc(op_cnt, 1'b1);
      err_cnt    <= sat_inc(err_cnt, mismatch);
      err_sticky <= err_sticky | mismatch;
    end
  end

endmodule
